logic_issue: RTL and testbench

Issue and writeback sequencer for the logic execution unit in `simple_processor`. It accepts encoded logic instructions over a valid/ready handshake and reads both source operands from a local register file. It drives `rs1_data`/`rs2_data`/`func_t` to the combinational `logic_gates` unit, then writes the returned result into the destination register. It sits between instruction fetch and the logic execution unit.

---
 rtl/sp_pkg.sv | 36 +++
 rtl/sp_regfile.sv | 47 ++++
 rtl/logic_issue.sv | 135 +++++++++++++
 tb/tb_logic_issue.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_pkg.sv
// Shared types and constants for the logic issue/writeback sequencer.
// LOGIC_ISSUE_ILLEGAL_TRAP_EN adds the HALT state used by the illegal-opcode trap.
package sp_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned FUNC_W     = 4;
    localparam int unsigned FIELD_W    = 4;

    typedef logic [FUNC_W-1:0] func_t;

    localparam func_t FUNC_AND = 4'b0101;
    localparam func_t FUNC_OR  = 4'b1101;
    localparam func_t FUNC_XOR = 4'b1111;
    localparam func_t FUNC_NOT = 4'b0111;

    typedef struct packed {
        func_t              func;
        logic [FIELD_W-1:0] rd;
        logic [FIELD_W-1:0] rs1;
        logic [FIELD_W-1:0] rs2;
    } logic_instr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE
`ifdef LOGIC_ISSUE_ILLEGAL_TRAP_EN
        ,
        ST_HALT
`endif
    } issue_state_e;

    function automatic logic is_legal_func(input func_t f);
        return (f == FUNC_AND) || (f == FUNC_OR) || (f == FUNC_XOR) || (f == FUNC_NOT);
    endfunction

endpackage

// File: rtl/sp_regfile.sv
// Flop-based register file: two operand read ports, one debug read port,
// two write ports where port 0 (writeback) wins an address collision.
module sp_regfile
    import sp_pkg::*;
#(
    parameter  int unsigned NUM_REGS = 16,
    localparam int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [AW-1:0]         ra0_addr_i,
    output logic [DATA_WIDTH-1:0] ra0_data_o,
    input  logic [AW-1:0]         ra1_addr_i,
    output logic [DATA_WIDTH-1:0] ra1_data_o,
    input  logic [AW-1:0]         dbg_addr_i,
    output logic [DATA_WIDTH-1:0] dbg_data_o,
    input  logic                  we0_i,
    input  logic [AW-1:0]         wa0_i,
    input  logic [DATA_WIDTH-1:0] wd0_i,
    input  logic                  we1_i,
    input  logic [AW-1:0]         wa1_i,
    input  logic [DATA_WIDTH-1:0] wd1_i
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    assign ra0_data_o = regs_q[ra0_addr_i];
    assign ra1_data_o = regs_q[ra1_addr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

    // Port 0 is applied last so it overrides port 1 on the same address.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (we1_i) begin
                regs_q[wa1_i] <= wd1_i;
            end
            if (we0_i) begin
                regs_q[wa0_i] <= wd0_i;
            end
        end
    end

endmodule

// File: rtl/logic_issue.sv
// Issue/writeback sequencer for the logic execution unit.
// Define LOGIC_ISSUE_ILLEGAL_TRAP_EN to trap illegal opcodes into a sticky HALT.
module logic_issue
    import sp_pkg::*;
#(
    parameter  int unsigned NUM_REGS = 16,
    localparam int unsigned REG_AW   = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [15:0]           instr_i,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    output logic [DATA_WIDTH-1:0] rs1_data_o,
    output logic [DATA_WIDTH-1:0] rs2_data_o,
    output func_t                 opcode_o,
    input  logic [DATA_WIDTH-1:0] result_i,
    input  logic                  ld_en_i,
    input  logic [REG_AW-1:0]     ld_addr_i,
    input  logic [DATA_WIDTH-1:0] ld_data_i,
    input  logic [REG_AW-1:0]     dbg_addr_i,
    output logic [DATA_WIDTH-1:0] dbg_data_o,
    output logic                  done_o,
    output logic [REG_AW-1:0]     done_rd_o,
    output logic                  err_o
);

    logic_instr_t          instr;
    issue_state_e          state_q;
    func_t                 func_q;
    logic [REG_AW-1:0]     rd_q;
    logic [REG_AW-1:0]     done_rd_q;
    logic [DATA_WIDTH-1:0] rs1_q;
    logic [DATA_WIDTH-1:0] rs2_q;
    logic [DATA_WIDTH-1:0] rs1_rdata;
    logic [DATA_WIDTH-1:0] rs2_rdata;
    logic                  ready_q;
    logic                  done_q;
    logic                  accept;
    logic                  wb_en;

    assign instr  = logic_instr_t'(instr_i);
    assign accept = instr_valid_i && ready_q;
    assign wb_en  = (state_q == ST_ISSUE) && is_legal_func(func_q);

    sp_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ra0_addr_i (instr.rs1[REG_AW-1:0]),
        .ra0_data_o (rs1_rdata),
        .ra1_addr_i (instr.rs2[REG_AW-1:0]),
        .ra1_data_o (rs2_rdata),
        .dbg_addr_i (dbg_addr_i),
        .dbg_data_o (dbg_data_o),
        .we0_i      (wb_en),
        .wa0_i      (rd_q),
        .wd0_i      (result_i),
        .we1_i      (ld_en_i),
        .wa1_i      (ld_addr_i),
        .wd1_i      (ld_data_i)
    );

`ifdef LOGIC_ISSUE_ILLEGAL_TRAP_EN
    logic err_q;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // Sequencer: capture operands on accept, write back on the following edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            func_q    <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            done_q    <= 1'b0;
            done_rd_q <= '0;
`ifdef LOGIC_ISSUE_ILLEGAL_TRAP_EN
            err_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_ISSUE;
                        ready_q <= 1'b0;
                        func_q  <= instr.func;
                        rd_q    <= instr.rd[REG_AW-1:0];
                        rs1_q   <= rs1_rdata;
                        rs2_q   <= rs2_rdata;
                    end
                end
                ST_ISSUE: begin
                    if (is_legal_func(func_q)) begin
                        state_q   <= ST_IDLE;
                        ready_q   <= 1'b1;
                        done_q    <= 1'b1;
                        done_rd_q <= rd_q;
                    end else begin
`ifdef LOGIC_ISSUE_ILLEGAL_TRAP_EN
                        state_q <= ST_HALT;
                        err_q   <= 1'b1;
`else
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
`endif
                    end
                end
`ifdef LOGIC_ISSUE_ILLEGAL_TRAP_EN
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign instr_ready_o = ready_q;
    assign rs1_data_o    = rs1_q;
    assign rs2_data_o    = rs2_q;
    assign opcode_o      = func_q;
    assign done_o        = done_q;
    assign done_rd_o     = done_rd_q;

endmodule

// File: tb/tb_logic_issue.sv
// Self-checking bench for logic_issue with a behavioural register-file model.
// Honours LOGIC_ISSUE_ILLEGAL_TRAP_EN when checking the illegal-opcode scenario.
module tb_logic_issue;
    import sp_pkg::*;

    localparam int unsigned NREG = 16;
    localparam int unsigned AW   = 4;
    localparam int unsigned DW   = DATA_WIDTH;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [15:0]   instr_i;
    logic          instr_valid_i;
    logic          instr_ready_o;
    logic [DW-1:0] rs1_data_o;
    logic [DW-1:0] rs2_data_o;
    func_t         opcode_o;
    logic [DW-1:0] result_i;
    logic          ld_en_i;
    logic [AW-1:0] ld_addr_i;
    logic [DW-1:0] ld_data_i;
    logic [AW-1:0] dbg_addr_i;
    logic [DW-1:0] dbg_data_o;
    logic          done_o;
    logic [AW-1:0] done_rd_o;
    logic          err_o;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [DW-1:0] m_regs [NREG];

    always #5 clk_i = ~clk_i;

    logic_issue #(.NUM_REGS(NREG)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .rs1_data_o    (rs1_data_o),
        .rs2_data_o    (rs2_data_o),
        .opcode_o      (opcode_o),
        .result_i      (result_i),
        .ld_en_i       (ld_en_i),
        .ld_addr_i     (ld_addr_i),
        .ld_data_i     (ld_data_i),
        .dbg_addr_i    (dbg_addr_i),
        .dbg_data_o    (dbg_data_o),
        .done_o        (done_o),
        .done_rd_o     (done_rd_o),
        .err_o         (err_o)
    );

    function automatic logic [DW-1:0] gate_op(input func_t f, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (f)
            4'b0101: return a & b;
            4'b1101: return a | b;
            4'b1111: return a ^ b;
            4'b0111: return ~a;
            default: return '0;
        endcase
    endfunction

    // Stand-in for the combinational logic_gates unit.
    always_comb result_i = gate_op(opcode_o, rs1_data_o, rs2_data_o);

    function automatic logic [15:0] mk(input logic [3:0] f, input int rd, input int a, input int b);
        return {f, 4'(rd), 4'(a), 4'(b)};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; instr_valid_i = 1'b0; ld_en_i = 1'b0;
        tick(); tick();
        rst_ni = 1'b1;
        for (int i = 0; i < int'(NREG); i++) m_regs[i] = '0;
    endtask

    task automatic load(input int addr, input logic [DW-1:0] data);
        ld_en_i = 1'b1; ld_addr_i = AW'(addr); ld_data_i = data;
        tick();
        ld_en_i = 1'b0;
        m_regs[addr] = data;
    endtask

    // Present an instruction and return one cycle after the accepting edge.
    task automatic send(input logic [15:0] ins, output bit timeout);
        timeout = 1'b1;
        instr_i = ins; instr_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (instr_ready_o) begin
                timeout = 1'b0;
                break;
            end
            tick();
        end
        tick();
        instr_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (instr_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", instr_ready_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
        n_cmp++; if ({rs1_data_o, rs2_data_o, opcode_o} !== '0) begin n_bad++;
            $display("FAIL reset_outs got=%h/%h/%h exp=0", rs1_data_o, rs2_data_o, opcode_o); end
        for (int i = 0; i < int'(NREG); i++) begin
            dbg_addr_i = AW'(i); #1;
            n_cmp++; if (dbg_data_o !== '0) begin n_bad++; $display("FAIL reset_reg r%0d got=%h exp=00", i, dbg_data_o); end
        end
    endtask

    task automatic test_and();
        bit to;
        load(1, 8'hF0); load(2, 8'h3C);
        send(mk(FUNC_AND, 3, 1, 2), to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL and_accept got=timeout exp=accept"); end
        n_cmp++; if (opcode_o !== 4'b0101) begin n_bad++; $display("FAIL and_opcode got=%b exp=0101", opcode_o); end
        n_cmp++; if (rs1_data_o !== 8'hF0 || rs2_data_o !== 8'h3C) begin n_bad++;
            $display("FAIL and_operands got=%h/%h exp=f0/3c", rs1_data_o, rs2_data_o); end
        n_cmp++; if (instr_ready_o !== 1'b0 || done_o !== 1'b0) begin n_bad++;
            $display("FAIL and_issue_cycle got ready=%b done=%b exp=0/0", instr_ready_o, done_o); end
        tick();
        dbg_addr_i = 4'd3; #1;
        n_cmp++; if (done_o !== 1'b1 || done_rd_o !== 4'd3) begin n_bad++;
            $display("FAIL and_done got=%b rd=%0d exp=1 rd=3", done_o, done_rd_o); end
        n_cmp++; if (dbg_data_o !== 8'h30) begin n_bad++; $display("FAIL and_result got=%h exp=30", dbg_data_o); end
        n_cmp++; if (instr_ready_o !== 1'b1) begin n_bad++; $display("FAIL and_ready_back got=%b exp=1", instr_ready_o); end
        m_regs[3] = 8'h30;
        tick();
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL and_done_single got=%b exp=0", done_o); end
    endtask

    task automatic test_back_to_back();
        int acc [2];
        int n_acc = 0;
        instr_i = mk(FUNC_OR, 4, 1, 2); instr_valid_i = 1'b1;
        for (int cyc = 0; cyc < 12 && n_acc < 2; cyc++) begin
            if (instr_ready_o) begin acc[n_acc] = cyc; n_acc++; end
            tick();
            if (n_acc == 1) instr_i = mk(FUNC_XOR, 5, 1, 2);
            if (n_acc == 2) instr_valid_i = 1'b0;
        end
        instr_valid_i = 1'b0;
        n_cmp++; if (n_acc != 2) begin n_bad++; $display("FAIL b2b_accepts got=%0d exp=2", n_acc); end
        else begin
            n_cmp++; if (acc[1] - acc[0] != 2) begin n_bad++; $display("FAIL b2b_spacing got=%0d exp=2", acc[1] - acc[0]); end
        end
        tick();
        m_regs[4] = 8'hFC; m_regs[5] = 8'hCC;
        dbg_addr_i = 4'd4; #1;
        n_cmp++; if (dbg_data_o !== 8'hFC) begin n_bad++; $display("FAIL b2b_or got=%h exp=fc", dbg_data_o); end
        dbg_addr_i = 4'd5; #1;
        n_cmp++; if (dbg_data_o !== 8'hCC) begin n_bad++; $display("FAIL b2b_xor got=%h exp=cc", dbg_data_o); end
        tick();
    endtask

    task automatic test_collision();
        bit to;
        send(mk(FUNC_NOT, 1, 1, 0), to);
        ld_en_i = 1'b1; ld_addr_i = 4'd1; ld_data_i = 8'hAA;
        tick();
        ld_en_i = 1'b0;
        dbg_addr_i = 4'd1; #1;
        n_cmp++; if (to || dbg_data_o !== 8'h0F) begin n_bad++; $display("FAIL coll_same got=%h exp=0f", dbg_data_o); end
        n_cmp++; if (done_o !== 1'b1 || done_rd_o !== 4'd1) begin n_bad++;
            $display("FAIL coll_done got=%b rd=%0d exp=1 rd=1", done_o, done_rd_o); end
        m_regs[1] = 8'h0F;
        send(mk(FUNC_NOT, 8, 2, 0), to);
        ld_en_i = 1'b1; ld_addr_i = 4'd9; ld_data_i = 8'h55;
        tick();
        ld_en_i = 1'b0;
        m_regs[8] = 8'hC3; m_regs[9] = 8'h55;
        dbg_addr_i = 4'd8; #1;
        n_cmp++; if (dbg_data_o !== 8'hC3) begin n_bad++; $display("FAIL coll_diff_wb got=%h exp=c3", dbg_data_o); end
        dbg_addr_i = 4'd9; #1;
        n_cmp++; if (dbg_data_o !== 8'h55) begin n_bad++; $display("FAIL coll_diff_ld got=%h exp=55", dbg_data_o); end
        tick();
    endtask

    // Random instructions and loads against a transaction-level model.
    task automatic test_random();
        func_t legal [4] = '{FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_NOT};
        bit            busy = 1'b0;
        bit            exp_done = 1'b0;
        func_t         p_func = '0;
        int            p_rd = 0;
        int            exp_rd = 0;
        logic [DW-1:0] p_a = '0;
        logic [DW-1:0] p_b = '0;
        logic [DW-1:0] wb_val;
        logic_instr_t  ri;
        bit            wb;
        int            a;
        for (int i = 0; i < 303; i++) begin
            n_cmp++; if (instr_ready_o !== !busy) begin n_bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, instr_ready_o, !busy); end
            n_cmp++; if (done_o !== exp_done) begin n_bad++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", i, done_o, exp_done); end
            if (exp_done) begin
                n_cmp++; if (done_rd_o !== AW'(exp_rd)) begin n_bad++; $display("FAIL rnd_done_rd cyc=%0d got=%0d exp=%0d", i, done_rd_o, exp_rd); end
            end
            if (busy) begin
                n_cmp++; if (opcode_o !== p_func || rs1_data_o !== p_a || rs2_data_o !== p_b) begin n_bad++;
                    $display("FAIL rnd_issue cyc=%0d got=%h/%h/%h exp=%h/%h/%h", i, opcode_o, rs1_data_o, rs2_data_o, p_func, p_a, p_b); end
            end
            a = int'($urandom_range(NREG - 1));
            dbg_addr_i = AW'(a); #1;
            n_cmp++; if (dbg_data_o !== m_regs[a]) begin n_bad++; $display("FAIL rnd_reg cyc=%0d r%0d got=%h exp=%h", i, a, dbg_data_o, m_regs[a]); end

            ri = logic_instr_t'(16'($urandom));
            ri.func = legal[$urandom_range(3)];
            instr_i = ri;
            instr_valid_i = (i < 300) && ($urandom_range(1) == 1);
            ld_en_i = (i < 300) && ($urandom_range(2) == 0);
            ld_addr_i = (busy && $urandom_range(1) == 1) ? AW'(p_rd) : AW'($urandom);
            ld_data_i = DW'($urandom);

            wb = busy && is_legal_func(p_func);
            wb_val = gate_op(p_func, p_a, p_b);
            exp_done = wb;
            exp_rd = p_rd;
            if (!busy && instr_valid_i) begin
                p_func = ri.func; p_rd = int'(ri.rd);
                p_a = m_regs[ri.rs1]; p_b = m_regs[ri.rs2];
                busy = 1'b1;
            end else begin
                busy = 1'b0;
            end
            if (ld_en_i) m_regs[ld_addr_i] = ld_data_i;
            if (wb) m_regs[exp_rd] = wb_val;
            tick();
        end
        instr_valid_i = 1'b0; ld_en_i = 1'b0;
    endtask

    task automatic test_illegal();
        bit to;
        send(mk(4'b0000, 7, 1, 2), to);
        n_cmp++; if (to || instr_ready_o !== 1'b0) begin n_bad++; $display("FAIL ill_issue got ready=%b exp=0", instr_ready_o); end
        tick();
        dbg_addr_i = 4'd7; #1;
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL ill_done got=%b exp=0", done_o); end
        n_cmp++; if (dbg_data_o !== m_regs[7]) begin n_bad++; $display("FAIL ill_nowb got=%h exp=%h", dbg_data_o, m_regs[7]); end
`ifdef LOGIC_ISSUE_ILLEGAL_TRAP_EN
        n_cmp++; if (err_o !== 1'b1 || instr_ready_o !== 1'b0) begin n_bad++;
            $display("FAIL ill_trap got err=%b ready=%b exp=1/0", err_o, instr_ready_o); end
        load(9, 8'h5A);
        tick(); tick();
        dbg_addr_i = 4'd9; #1;
        n_cmp++; if (dbg_data_o !== 8'h5A) begin n_bad++; $display("FAIL ill_halt_load got=%h exp=5a", dbg_data_o); end
        n_cmp++; if (err_o !== 1'b1 || instr_ready_o !== 1'b0) begin n_bad++;
            $display("FAIL ill_halt_sticky got err=%b ready=%b exp=1/0", err_o, instr_ready_o); end
`else
        n_cmp++; if (err_o !== 1'b0 || instr_ready_o !== 1'b1) begin n_bad++;
            $display("FAIL ill_discard got err=%b ready=%b exp=0/1", err_o, instr_ready_o); end
`endif
    endtask

    task automatic test_reset_mid_issue();
        bit to;
        do_reset();
        load(1, 8'hF0); load(2, 8'h3C);
        send(mk(FUNC_XOR, 6, 1, 2), to);
        n_cmp++; if (to || opcode_o !== FUNC_XOR) begin n_bad++; $display("FAIL rst_mid_issue got=%b exp=1111", opcode_o); end
        rst_ni = 1'b0;
        tick();
        for (int i = 0; i < int'(NREG); i++) m_regs[i] = '0;
        dbg_addr_i = 4'd6; #1;
        n_cmp++; if (done_o !== 1'b0 || instr_ready_o !== 1'b1 || err_o !== 1'b0) begin n_bad++;
            $display("FAIL rst_mid_ctrl got done=%b ready=%b err=%b exp=0/1/0", done_o, instr_ready_o, err_o); end
        n_cmp++; if ({rs1_data_o, rs2_data_o, opcode_o} !== '0) begin n_bad++;
            $display("FAIL rst_mid_outs got=%h/%h/%h exp=0", rs1_data_o, rs2_data_o, opcode_o); end
        n_cmp++; if (dbg_data_o !== 8'h00) begin n_bad++; $display("FAIL rst_mid_r6 got=%h exp=00", dbg_data_o); end
        rst_ni = 1'b1;
        tick();
        n_cmp++; if (done_o !== 1'b0 || dbg_data_o !== 8'h00) begin n_bad++;
            $display("FAIL rst_mid_late got done=%b r6=%h exp=0/00", done_o, dbg_data_o); end
    endtask

    initial begin
        rst_ni = 1'b0; instr_i = '0; instr_valid_i = 1'b0;
        ld_en_i = 1'b0; ld_addr_i = '0; ld_data_i = '0; dbg_addr_i = '0;
        test_reset();
        test_and();
        test_back_to_back();
        test_collision();
        test_random();
        test_illegal();
        test_reset_mid_issue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
